// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one load/store to a stalling data memory through an
// enable/stall/done handshake, holds the core busy until retirement, flags a sticky error.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ex_out,
    input  logic [15:0] st_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        halt,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    input  logic        mem_done,
    output logic [15:0] wb_data,
    output logic        mem_busy,
    output logic        mem_valid,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] wb_q, wb_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        req;
    logic        bad_req;
    logic        timeout_hit;

    // Halt masks the whole request, including the malformed-request check.
    assign req         = (mem_rd | mem_wr) & ~halt;
    assign bad_req     = req & ((mem_rd & mem_wr) | ex_out[0]);
    assign timeout_hit = (cnt_q == 4'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            wb_q    <= 16'd0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wb_q    <= wb_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bad_req) begin
                    state_d = S_ERR;
                end else if (req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!mem_stall) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done arriving on the final allowed cycle still retires the access.
                if (mem_done) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_busy = 1'b0;
        wb_data  = wb_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wb_d     = wb_q;
        case (state_q)
            S_IDLE: begin
                wb_data  = ex_out;
                mem_busy = req;
                if (req && !bad_req) begin
                    addr_d  = ex_out;
                    wdata_d = st_data;
                    op_wr_d = mem_wr;
                end
            end
            S_REQ: begin
                mem_busy = 1'b1;
                cnt_d    = 4'd0;
            end
            S_WAIT: begin
                mem_busy = 1'b1;
                cnt_d    = cnt_q + 4'd1;
                if (mem_done) begin
                    wb_d = op_wr_q ? wdata_q : mem_rdata;
                end
            end
            S_DONE:  mem_busy = 1'b0;
            S_ERR:   mem_busy = 1'b1;
            default: mem_busy = 1'b0;
        endcase

        // Strobes, valid and err are registered from the next state so they line up with it.
        rd_en_d = (state_d == S_REQ) & ~op_wr_d;
        wr_en_d = (state_d == S_REQ) & op_wr_d;
        valid_d = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign mem_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: reactive memory model plus a timeline
// reference derived from stall count and done delay of each access.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ex_out = 16'd0;
    logic [15:0] st_data = 16'd0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_stall = 1'b0;
    logic        mem_done = 1'b0;
    logic [15:0] wb_data;
    logic        mem_busy;
    logic        mem_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ex_out(ex_out), .st_data(st_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halt(halt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
        .wb_data(wb_data), .mem_busy(mem_busy), .mem_valid(mem_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic quiet_inputs();
        mem_rd = 1'b0; mem_wr = 1'b0; halt = 1'b0;
        mem_done = 1'b0; mem_stall = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with the DUT in IDLE.
    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One access: S stall cycles, done on WAIT cycle D (D outside 1..15 => timeout).
    // Expected timeline (k=0 issue): strobe k=1..S+1, WAIT k=S+2..S+1+D, DONE k=S+2+D,
    // or ERR from k=S+17 when done never arrives in time.
    task automatic run_txn(input bit wr, input logic [15:0] a, input logic [15:0] sd,
                           input logic [15:0] rdv, input int S, input int D, input string tag);
        int  last, stall_left, wctr;
        bit  ok, active, exp_busy, exp_str, exp_valid, exp_err;
        ok = (D >= 1 && D <= 15);
        last = ok ? S + 3 + D : S + 19;
        stall_left = S; active = 1'b0; wctr = 0;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                mem_rd = ~wr; mem_wr = wr; ex_out = a; st_data = sd; halt = 1'b0;
            end else if (ok && k == S + 3 + D) begin
                mem_rd = 1'b0; mem_wr = 1'b0; halt = 1'b0; ex_out = 16'($urandom);
            end else begin
                mem_rd = 1'($urandom); mem_wr = 1'($urandom); halt = 1'($urandom);
                ex_out = 16'($urandom); st_data = 16'($urandom);
            end
            mem_done = 1'b0; mem_stall = 1'b0; mem_rdata = 16'($urandom);
            if (mem_rd_en || mem_wr_en) begin
                if (stall_left > 0) begin
                    mem_stall = 1'b1; stall_left--;
                end else begin
                    active = 1'b1; wctr = 0;
                end
            end else if (active) begin
                wctr++;
                if (wctr == D) begin
                    mem_done = 1'b1; mem_rdata = rdv; active = 1'b0;
                end
            end
            @(negedge clk);
            exp_busy  = ok ? (k <= S + 1 + D) : 1'b1;
            exp_str   = (k >= 1 && k <= S + 1);
            exp_valid = ok && (k == S + 2 + D);
            exp_err   = !ok && (k >= S + 17);
            checks++;
            if (mem_busy !== exp_busy) begin
                errors++; $display("FAIL %s busy k=%0d got %b exp %b", tag, k, mem_busy, exp_busy);
            end
            checks++;
            if (mem_rd_en !== (exp_str && !wr) || mem_wr_en !== (exp_str && wr)) begin
                errors++;
                $display("FAIL %s strobes k=%0d got rd=%b wr=%b exp rd=%b wr=%b", tag, k,
                         mem_rd_en, mem_wr_en, exp_str && !wr, exp_str && wr);
            end
            if (exp_str) begin
                checks++;
                if (mem_addr !== a || mem_wdata !== sd) begin
                    errors++;
                    $display("FAIL %s addr/data k=%0d got %h/%h exp %h/%h", tag, k,
                             mem_addr, mem_wdata, a, sd);
                end
            end
            checks++;
            if (mem_valid !== exp_valid) begin
                errors++; $display("FAIL %s valid k=%0d got %b exp %b", tag, k, mem_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (wb_data !== (wr ? sd : rdv)) begin
                    errors++; $display("FAIL %s wb_data got %h exp %h", tag, wb_data, wr ? sd : rdv);
                end
            end
            if (ok && k == S + 3 + D) begin
                checks++;
                if (wb_data !== ex_out) begin
                    errors++; $display("FAIL %s passthru got %h exp %h", tag, wb_data, ex_out);
                end
            end
            checks++;
            if (err !== exp_err) begin
                errors++; $display("FAIL %s err k=%0d got %b exp %b", tag, k, err, exp_err);
            end
            @(posedge clk);
            #1;
        end
        quiet_inputs();
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_wdata, mem_rd_en, mem_wr_en, mem_valid, err, mem_busy} !== 37'd0) begin
            errors++;
            $display("FAIL reset outputs got addr=%h wdata=%h rd=%b wr=%b v=%b e=%b b=%b exp 0",
                     mem_addr, mem_wdata, mem_rd_en, mem_wr_en, mem_valid, err, mem_busy);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 16'h7F00 : 16'($urandom);
            ex_out = v; mem_rd = 1'b0; mem_wr = 1'b0;
            @(negedge clk);
            checks++;
            if (wb_data !== v || mem_busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL passthru wb=%h busy=%b rd=%b wr=%b exp wb=%h busy=0 no strobes",
                         wb_data, mem_busy, mem_rd_en, mem_wr_en, v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_halt();
        ex_out = 16'h0010; mem_rd = 1'b1; mem_wr = 1'b0; halt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_busy !== 1'b0) begin
            errors++; $display("FAIL halt busy got %b exp 0", mem_busy);
        end
        @(posedge clk);
        #1;
        quiet_inputs();
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b0 || mem_busy !== 1'b0) begin
            errors++; $display("FAIL halt no-issue got rd=%b busy=%b exp 0/0", mem_rd_en, mem_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_error(input bit both, input string tag);
        ex_out = both ? 16'h0020 : 16'h0003; mem_rd = 1'b1; mem_wr = both; halt = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 6; k++) begin
            mem_rd = 1'($urandom); mem_wr = 1'($urandom); mem_done = 1'($urandom);
            mem_stall = 1'($urandom); ex_out = 16'($urandom);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || mem_busy !== 1'b1 || mem_rd_en !== 1'b0 ||
                mem_wr_en !== 1'b0 || mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s sticky k=%0d got err=%b busy=%b rd=%b wr=%b v=%b exp 1 1 0 0 0",
                         tag, k, err, mem_busy, mem_rd_en, mem_wr_en, mem_valid);
            end
            @(posedge clk);
            #1;
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL %s err after rst got %b exp 0", tag, err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 16'h0080, 16'h0000, 16'h5555, 0, 0, "timeout_none");
        do_reset();
        run_txn(1'b0, 16'h0082, 16'h0000, 16'hA5A5, 1, 16, "timeout_late");
        do_reset();
        run_txn(1'b0, 16'h0084, 16'h0000, 16'hC3C3, 0, 15, "done_at_15");
        run_txn(1'b1, 16'h0086, 16'h9999, 16'h0000, 2, 14, "store_at_14");
    endtask

    task automatic test_reset_mid_access();
        ex_out = 16'h0040; mem_rd = 1'b1; mem_wr = 1'b0;
        @(posedge clk);
        #1;
        quiet_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_busy !== 1'b1) begin
            errors++; $display("FAIL midrst busy before rst got %b exp 1", mem_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_addr, mem_wdata, mem_rd_en, mem_wr_en, mem_valid, err, mem_busy} !== 37'd0) begin
            errors++;
            $display("FAIL midrst async got addr=%h wdata=%h rd=%b wr=%b v=%b e=%b b=%b exp 0",
                     mem_addr, mem_wdata, mem_rd_en, mem_wr_en, mem_valid, err, mem_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        checks++;
        if (mem_busy !== 1'b0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL stray done busy=%b valid=%b exp 0/0", mem_busy, mem_valid);
        end
        @(posedge clk);
        #1;
        mem_done = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || wb_data !== ex_out) begin
            errors++; $display("FAIL stray done after valid=%b wb=%h exp 0/%h", mem_valid, wb_data, ex_out);
        end
        @(posedge clk);
        #1;
        run_txn(1'b0, 16'h0044, 16'h0000, 16'h1357, 0, 1, "after_rst");
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom) & 16'hFFFE;
            run_txn(1'($urandom), a, 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 15)), "random");
        end
    endtask

    initial begin
        test_reset();
        run_txn(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 1, "load_basic");
        run_txn(1'b1, 16'h0102, 16'h1234, 16'h0000, 2, 1, "store_stall");
        test_passthrough();
        test_halt();
        test_error(1'b0, "misaligned");
        test_error(1'b1, "rd_and_wr");
        test_timeout();
        test_reset_mid_access();
        test_random();
        // Back-to-back: the DONE bubble is exercised by issuing immediately after the idle cycle.
        run_txn(1'b1, 16'h0200, 16'hCAFE, 16'h0000, 0, 1, "b2b_0");
        run_txn(1'b0, 16'h0202, 16'h0000, 16'hF00D, 0, 1, "b2b_1");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
